uart_receiver: RTL
==================

# uart_receiver

Serial receive front end for the memory-mapped UART peripheral: samples the asynchronous `UART_RX` pin, deframes 8N1 characters (8E1 when parity is compiled in) and presents each byte with a valid flag to the peripheral register block. It sits directly upstream of the UART receive-data and status registers read by the CPU through `MEM`. Its `rx_valid` rising edge is the source of the receive interrupt.

## Interface
- `CLK_FREQ`, default 100_000_000: `sysclk` frequency in Hz.
- `BAUD`, default 9600: line rate in bit/s.
- `CLKS_PER_BIT` (localparam) = `CLK_FREQ / BAUD`, truncating integer division; must be ≥ 4.

- `sysclk  in  1`: single clock; every flop is on its rising edge.
- `reset  in  1`: asynchronous, active-low (`negedge reset`).
- `UART_RX  in  1`: asynchronous serial line, idle high.
- `rx_read  in  1`: one-cycle pulse from the register block that consumes `rx_data`.
- `rx_data  out  8`: last good byte; reset 0x00.
- `rx_valid  out  1`: byte held and unread; reset 0.
- `rx_overrun  out  1`: sticky; a byte was lost; reset 0.
- `frame_err  out  1`: one-cycle pulse on a bad stop bit; reset 0.
- `parity_err  out  1`: one-cycle pulse on a parity mismatch; reset 0. Tied to 0 without the macro.
- `rx_busy  out  1`: FSM not in IDLE; reset 0.

## Operation
- `UART_RX` passes through a 2-flop synchronizer. Both flops reset to 1. The FSM acts only on the synchronized value `rxs`.
- A bit counter counts 0..`CLKS_PER_BIT`-1. It is cleared on every state entry.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, BREAK.
- IDLE: if `rxs`=0, go to START.
- START: at count `CLKS_PER_BIT/2`, sample `rxs`.
  - If 1: false start, return to IDLE. No flags.
  - If 0: go to DATA. From here, sampling falls at mid-bit.
- DATA: every `CLKS_PER_BIT` counts, shift `rxs` into a shift register, LSB first. After the 8th bit, go to PARITY (macro) or STOP.
- PARITY: sample after `CLKS_PER_BIT` counts and compare with even parity of the shift register. On mismatch, latch a mismatch flag. Go to STOP.
- STOP: sample after `CLKS_PER_BIT` counts. Transition to IDLE immediately after the stop sample.
  - `rxs`=1 and no parity mismatch: deliver the byte.
  - `rxs`=1 with a parity mismatch: pulse `parity_err`, discard the byte, go to IDLE.
  - `rxs`=0: pulse `frame_err`, discard the byte, go to BREAK.
- BREAK: wait for `rxs`=1, then go to IDLE. A line held low produces exactly one `frame_err`.
- Delivery:
  - If `rx_valid`=0, or `rx_read`=1 in the same cycle: load `rx_data`, set `rx_valid`=1.
  - Otherwise (`rx_valid`=1 and no read): keep the old `rx_data`, set `rx_overrun`=1.
- `rx_read` clears `rx_valid` and `rx_overrun` in the next cycle, unless a delivery happens in the same cycle, in which case `rx_valid` stays 1.
- `rx_read` while `rx_valid`=0 has no effect.

## Timing
- Latency: 2 cycles of synchronizer, then the START mid-bit, then 8 data bits (9 with parity), then the stop-bit sample. `rx_valid` rises one cycle after the stop-bit sample, about 9.5 bit times (10.5 with parity) after the start edge.
- `frame_err` and `parity_err` are high for exactly one cycle, aligned with the cycle where `rx_valid` would have risen.
- Back-to-back frames are supported: the FSM is back in IDLE about half a bit before the next start edge.
- Asynchronous reset mid-frame forces IDLE, clears all outputs and the shift register, and sets the synchronizer to 1. A partial frame is discarded, not reported.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1 and the PARITY state exists; `parity_err` is live.
- Not defined: frame is 8N1; the PARITY state and its logic are absent; `parity_err` is constant 0.

## Structure
- Package `uart_pkg`: the FSM state enum `uart_rx_state_t` and a shared `clks_per_bit(clk_freq, baud)` function, which the transmitter reuses.
- One sub-module, `uart_bit_timer`. It holds the bit counter with clear and the half-bit/full-bit tick outputs, parameterized by `CLKS_PER_BIT`.

## Test plan
Bench uses `CLK_FREQ`=16 and `BAUD`=1, so `CLKS_PER_BIT`=16.
- Line bits 0,1,1,1,0,0,0,0,0,1 (start, data LSB first, stop) → `rx_data`=0x07; `rx_valid` rises 1 cycle after the stop sample; no error flags.
- 0x07 left unread, then frame 0,1,0,0,0,0,0,0,0,1 → `rx_data` stays 0x07 and `rx_overrun`=1. Pulse `rx_read` → both flags clear.
- `rx_read` pulsed in the same cycle as delivery of 0x01 → `rx_valid` stays 1, `rx_data`=0x01, `rx_overrun`=0.
- Low glitch of 5 cycles on an idle line → returns to IDLE; `rx_busy` deasserts; no flags; `rx_valid` stays 0.
- Frame 0x55 with stop bit 0, line held low for 3 bit times → exactly one `frame_err` pulse, `rx_valid`=0. The next good frame 0xA3 is received.
- `reset` asserted during the 4th data bit → all outputs 0 on the next edge. A following 0x5A frame is received correctly.
- Macro build only: 0x03 sent with parity bit 1 → one `parity_err` pulse and no `rx_valid`. Sent with parity bit 0 → `rx_data`=0x03.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and baud divisor helper.
// The PARITY state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } uart_rx_state_t;

    // Truncating divide; the transmitter uses the same helper so both sides agree.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter for the UART receiver: counts 0..CLKS_PER_BIT-1 with a
// synchronous clear and flags the mid-bit and last-count positions.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic sysclk,
    input  logic reset,
    input  logic clear,
    output logic half_tick,
    output logic full_tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);

    logic [CW-1:0] count;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign half_tick = (count == HALF);
    assign full_tick = (count == LAST);

endmodule

// File: rtl/uart_receiver.sv
// UART receive front end: synchronizes UART_RX, deframes 8N1 characters
// (8E1 with UART_RX_PARITY_EN) and hands bytes to the register block.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       rx_read,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_overrun,
    output logic       frame_err,
    output logic       parity_err,
    output logic       rx_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    uart_rx_state_t state, next_state;

    logic       sync1;
    logic       rxs;
    logic       timer_clear;
    logic       half_tick;
    logic       full_tick;
    logic [2:0] bit_idx;
    logic [7:0] shift;
    logic       shift_en;
    logic       deliver;
    logic       frame_pulse;
`ifdef UART_RX_PARITY_EN
    logic       parity_check;
    logic       parity_pulse;
    logic       parity_bad;
`endif

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= UART_RX;
            rxs   <= sync1;
        end
    end

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .sysclk    (sysclk),
        .reset     (reset),
        .clear     (timer_clear),
        .half_tick (half_tick),
        .full_tick (full_tick)
    );

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        shift_en     = 1'b0;
        deliver      = 1'b0;
        frame_pulse  = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_check = 1'b0;
        parity_pulse = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rxs) next_state = ST_START;
            end
            ST_START: begin
                if (half_tick) next_state = rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (full_tick) begin
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        next_state = ST_PARITY;
`else
                        next_state = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (full_tick) begin
                    parity_check = 1'b1;
                    next_state   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (full_tick) begin
                    if (rxs) begin
`ifdef UART_RX_PARITY_EN
                        if (parity_bad) parity_pulse = 1'b1;
                        else            deliver      = 1'b1;
`else
                        deliver = 1'b1;
`endif
                        next_state = ST_IDLE;
                    end else begin
                        frame_pulse = 1'b1;
                        next_state  = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Restarting the timer on every state change puts DATA samples at mid-bit.
    assign timer_clear = (next_state != state);
    assign rx_busy     = (state != ST_IDLE);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            bit_idx <= 3'd0;
            shift   <= 8'h00;
        end else begin
            if (state != ST_DATA)  bit_idx <= 3'd0;
            else if (full_tick)    bit_idx <= bit_idx + 3'd1;
            if (shift_en)          shift   <= {rxs, shift[7:1]};
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            parity_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= parity_pulse;
            if (state == ST_IDLE)                      parity_bad <= 1'b0;
            else if (parity_check && (rxs != ^shift))  parity_bad <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

    // A delivery while a byte is still unread keeps the old byte and flags the loss.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            frame_err <= frame_pulse;
            if (deliver) begin
                if (!rx_valid || rx_read) begin
                    rx_data  <= shift;
                    rx_valid <= 1'b1;
                    if (rx_read) rx_overrun <= 1'b0;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_read && rx_valid) begin
                rx_valid   <= 1'b0;
                rx_overrun <= 1'b0;
            end
        end
    end

endmodule
